// File: rtl/if_stage_bp.sv
// Instruction-fetch stage: fetch PC, direct-mapped BTB and saturating-counter direction prediction.
// Latency: if_addr is combinational from all redirect inputs; a BTB update is visible to lookup one cycle later.
// Backpressure: id_stall holds the PC unless an EX mispredict forces a redirect; BTB training is never stalled.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   id_stall             hold the PC (overridden by ex_br_mispred)
//   id_target_taken/id_target        decode-resolved direct jump
//   ex_br_mispred/ex_redirect_pc     EX mispredict redirect (highest priority)
//   ex_update_valid/_pc/_taken/_target  BTB training from resolved branches
//   id_pc                PC of the instruction in decode (the PC register)
//   if_addr              next fetch address
//   id_pred_taken/id_pred_target     prediction for the instruction at id_pc
module if_stage_bp #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h4000_0000),
  parameter int              BTB_ENTRIES = 64,
  parameter int              CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall,
  input  logic            id_target_taken,
  input  logic [XLEN-1:0] id_target,
  input  logic            ex_br_mispred,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            ex_update_valid,
  input  logic [XLEN-1:0] ex_update_pc,
  input  logic            ex_update_taken,
  input  logic [XLEN-1:0] ex_update_target,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] if_addr,
  output logic            id_pred_taken,
  output logic [XLEN-1:0] id_pred_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // Counter encodings: MSB set means "predict taken".
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
  logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

  logic [XLEN-1:0]  pc;
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             pc_we;
  logic [1:0]       unused_upd_lsb;

  // Instructions are word aligned; the byte-offset bits of the update PC carry no information.
  assign unused_upd_lsb = ex_update_pc[1:0];

  assign id_pc = pc;

  // ---------------------------------------------------------------------------
  // Lookup: reads the registered array, so a same-cycle write is not seen.
  // ---------------------------------------------------------------------------
  assign look_idx       = pc[IDX+1:2];
  assign look_tag       = pc[XLEN-1:IDX+2];
  assign look_hit       = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign id_pred_taken  = look_hit && btb_ctr[look_idx][CTR_BITS-1];
  assign id_pred_target = btb_target[look_idx];

  // ---------------------------------------------------------------------------
  // Next fetch address
  // ---------------------------------------------------------------------------
  always_comb begin
    if_addr = pc + XLEN'(4);
    if (ex_br_mispred)        if_addr = ex_redirect_pc;
    else if (id_stall)        if_addr = pc;
    else if (id_target_taken) if_addr = id_target;
    else if (id_pred_taken)   if_addr = id_pred_target;
  end

  // A mispredict must redirect even while decode is stalled.
  assign pc_we = ex_br_mispred || !id_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC - XLEN'(4);
    end else if (pc_we) begin
      pc <= if_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // BTB training
  // ---------------------------------------------------------------------------
  assign upd_idx = ex_update_pc[IDX+1:2];
  assign upd_tag = ex_update_pc[XLEN-1:IDX+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_WNT;
      end
    end else if (ex_update_valid) begin
      if (upd_hit) begin
        if (ex_update_taken) begin
          if (btb_ctr[upd_idx] != CTR_MAX) begin
            btb_ctr[upd_idx] <= btb_ctr[upd_idx] + CTR_BITS'(1);
          end
          btb_target[upd_idx] <= ex_update_target;
        end else if (btb_ctr[upd_idx] != '0) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - CTR_BITS'(1);
        end
      end else if (ex_update_taken) begin
        // Miss or alias: a taken branch claims the slot, starting weakly taken.
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= ex_update_target;
        btb_ctr[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_bp.sv
module tb_if_stage_bp;

  localparam int N    = 64;
  localparam int CB   = 2;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CWT  = 1 << (CB - 1);

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic        id_target_taken;
  logic [31:0] id_target;
  logic        ex_br_mispred;
  logic [31:0] ex_redirect_pc;
  logic        ex_update_valid;
  logic [31:0] ex_update_pc;
  logic        ex_update_taken;
  logic [31:0] ex_update_target;
  logic [31:0] id_pc;
  logic [31:0] if_addr;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;

  if_stage_bp #(
    .XLEN(32), .RESET_PC(32'h4000_0000), .BTB_ENTRIES(N), .CTR_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .id_stall(id_stall), .id_target_taken(id_target_taken), .id_target(id_target),
    .ex_br_mispred(ex_br_mispred), .ex_redirect_pc(ex_redirect_pc),
    .ex_update_valid(ex_update_valid), .ex_update_pc(ex_update_pc),
    .ex_update_taken(ex_update_taken), .ex_update_target(ex_update_target),
    .id_pc(id_pc), .if_addr(if_addr),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the full address of the branch that
  // owns it; a lookup hits when the owner lies in the same 4*N-byte aliasing
  // window as the looked-up PC.
  logic [31:0] m_pc;
  bit          m_vld   [N];
  logic [31:0] m_owner [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int slot(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s;
    s = slot(a);
    return m_vld[s] && ((m_owner[s] / (4 * N)) == (a / (4 * N)));
  endfunction

  task automatic model_reset();
    m_pc = 32'h4000_0000 - 32'd4;
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_ctr[i] = CWT - 1;
    end
  endtask

  task automatic set_idle();
    id_stall = 0; id_target_taken = 0; id_target = '0;
    ex_br_mispred = 0; ex_redirect_pc = '0;
    ex_update_valid = 0; ex_update_pc = '0; ex_update_taken = 0; ex_update_target = '0;
  endtask

  // Inputs are already applied (at negedge). Check outputs, clock, advance model.
  task automatic step();
    bit          hit, pt;
    logic [31:0] nxt;
    int          s;
    #1;
    s   = slot(m_pc);
    hit = m_hit(m_pc);
    pt  = hit && (m_ctr[s] >= CWT);
    if (ex_br_mispred)        nxt = ex_redirect_pc;
    else if (id_stall)        nxt = m_pc;
    else if (id_target_taken) nxt = id_target;
    else if (pt)              nxt = m_tgt[s];
    else                      nxt = m_pc + 32'd4;
    chk("id_pc", id_pc, m_pc);
    chk("pred_taken", 32'(id_pred_taken), 32'(pt));
    if (hit) chk("pred_target", id_pred_target, m_tgt[s]);
    chk("if_addr", if_addr, nxt);
    @(posedge clk);
    m_pc = nxt;
    if (ex_update_valid) begin
      s = slot(ex_update_pc);
      if (m_hit(ex_update_pc)) begin
        if (ex_update_taken) begin
          m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
          m_tgt[s] = ex_update_target;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (ex_update_taken) begin
        m_vld[s]   = 1'b1;
        m_owner[s] = ex_update_pc;
        m_tgt[s]   = ex_update_target;
        m_ctr[s]   = CWT;
      end
    end
    @(negedge clk);
  endtask

  // Reset is held across a clock edge with whatever update is on the inputs;
  // that update must be lost.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    model_reset();
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    ex_update_valid = 1; ex_update_pc = pc; ex_update_taken = taken; ex_update_target = tgt;
  endtask

  task automatic redirect(input logic [31:0] pc);
    set_idle();
    ex_br_mispred = 1; ex_redirect_pc = pc;
    step();
    set_idle();
  endtask

  function automatic logic [31:0] pick();
    return 32'h4000_0000 + 32'(4 * $urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 32'd256 : 32'd0);
  endfunction

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    do_reset();

    // Reset state and free-running sequential fetch
    #1;
    chk("rst_if_addr", if_addr, 32'h4000_0000);
    chk("rst_id_pc", id_pc, 32'h3FFF_FFFC);
    chk("rst_pred", 32'(id_pred_taken), 32'd0);
    step();
    chk("seq1_if_addr", if_addr, 32'h4000_0004);
    step();
    chk("seq2_if_addr", if_addr, 32'h4000_0008);
    step();

    // Allocate 0x10 -> 0x100, then land on it
    upd(32'h4000_0010, 1, 32'h4000_0100);
    step();
    set_idle();
    redirect(32'h4000_0010);
    #1;
    chk("alloc_pred", 32'(id_pred_taken), 32'd1);
    chk("alloc_if_addr", if_addr, 32'h4000_0100);

    // Counter walk-down while stalled at 0x10: 2 -> 1
    id_stall = 1; upd(32'h4000_0010, 0, '0);
    step();
    set_idle();
    #1;
    chk("nt1_pred", 32'(id_pred_taken), 32'd0);
    chk("nt1_if_addr", if_addr, 32'h4000_0014);
    id_stall = 1; upd(32'h4000_0010, 0, '0);          // 1 -> 0
    step();
    id_stall = 1; upd(32'h4000_0010, 0, '0);          // stays 0
    step();
    id_stall = 1; upd(32'h4000_0010, 1, 32'h4000_0100); // 0 -> 1
    step();
    id_stall = 1; ex_update_valid = 0;
    #1;
    chk("sat0_pred", 32'(id_pred_taken), 32'd0);
    upd(32'h4000_0010, 1, 32'h4000_0100);              // 1 -> 2
    step();
    set_idle();
    #1;
    chk("rearm_pred", 32'(id_pred_taken), 32'd1);

    // Mispredict beats stall and prediction
    id_stall = 1; ex_br_mispred = 1; ex_redirect_pc = 32'h4000_0200;
    #1;
    chk("mispred_if_addr", if_addr, 32'h4000_0200);
    step();
    set_idle();
    chk("mispred_id_pc", id_pc, 32'h4000_0200);

    // Plain stall, then stall with a decode jump
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_if_addr", if_addr, 32'h4000_0200);
      step();
    end
    id_target_taken = 1; id_target = 32'h4000_0300;
    #1;
    chk("stall_jmp_if_addr", if_addr, 32'h4000_0200);
    step();
    set_idle();
    chk("stall_jmp_id_pc", id_pc, 32'h4000_0200);

    // Alias of 0x10 one BTB span higher
    redirect(32'h4000_0010 + 32'(4 * N));
    #1;
    chk("alias_pred", 32'(id_pred_taken), 32'd0);
    id_stall = 1; upd(32'h4000_0010 + 32'(4 * N), 0, '0);
    step();
    set_idle();
    redirect(32'h4000_0010);
    #1;
    chk("alias_keep_pred", 32'(id_pred_taken), 32'd1);
    chk("alias_keep_tgt", id_pred_target, 32'h4000_0100);

    // Reset with an update in flight
    upd(32'h4000_0020, 1, 32'h4000_0400);
    do_reset();
    redirect(32'h4000_0020);
    #1;
    chk("rst_drop_pred", 32'(id_pred_taken), 32'd0);
    chk("rst_drop_old", 32'(m_hit(32'h4000_0010)), 32'd0);

    // Randomised traffic around a small code window
    for (int c = 0; c < 3000; c++) begin
      id_stall         = ($urandom_range(0, 4) == 0);
      id_target_taken  = ($urandom_range(0, 9) == 0);
      id_target        = pick();
      ex_br_mispred    = ($urandom_range(0, 7) == 0) || (m_pc > 32'h4000_0200);
      ex_redirect_pc   = pick();
      ex_update_valid  = ($urandom_range(0, 1) == 0);
      ex_update_pc     = pick();
      ex_update_taken  = ($urandom_range(0, 9) < 6);
      ex_update_target = pick();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_bp.md
Name: if_stage_bp

Overview:
Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and saturating-counter direction prediction.
- Holds the fetch PC and produces the next fetch address.
- Predicts taken control flow for the instruction at id_pc and redirects on decode-resolved targets and on execute mispredicts.
- Sits between instruction memory (if_addr) and the decode stage (id_pc, id_pred_*). EX trains it via the update port.

Parameters:
- RESET_PC, 32'h4000_0000, first fetched address. The PC register resets to RESET_PC-4.
- XLEN, 32, address/data width.
- BTB_ENTRIES, 64, BTB depth. Power of two, ≥2.
- CTR_BITS, 2, saturating-counter width, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_stall  in  1  decode stall; hold PC
- id_target_taken  in  1  decode resolved a direct jump
- id_target  in  XLEN  decode-resolved target
- ex_br_mispred  in  1  EX detected a mispredict
- ex_redirect_pc  in  XLEN  correct PC after mispredict
- ex_update_valid  in  1  EX resolved a branch/jump this cycle
- ex_update_pc  in  XLEN  PC of the resolved instruction
- ex_update_taken  in  1  resolved direction
- ex_update_target  in  XLEN  resolved taken target
- id_pc  out  XLEN  PC of the instruction in decode (PC register)
- if_addr  out  XLEN  next fetch address (combinational)
- id_pred_taken  out  1  prediction for the instruction at id_pc
- id_pred_target  out  XLEN  predicted target; valid when id_pred_taken

Behaviour:
- Reset (async, rst=1):
  - PC = RESET_PC-4.
  - All BTB valid bits cleared.
  - All counters set to weakly-not-taken, 2^(CTR_BITS-1)-1.
  - Resulting outputs: if_addr = RESET_PC, id_pred_taken = 0.
  - Reset mid-operation discards any in-flight update.
- Indexing:
  - idx = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - tag = pc[XLEN-1:IDX+2].
  - Entry fields: valid, tag, target, ctr.
- Lookup:
  - Combinational on id_pc, reading the registered array.
  - hit = valid & tag match.
  - id_pred_taken = hit & ctr[MSB].
  - id_pred_target = entry target. It is don't-care when not predicted; drive the entry value anyway.
- Next-PC priority, highest first:
  1. ex_br_mispred → ex_redirect_pc
  2. id_stall → id_pc (hold)
  3. id_target_taken → id_target
  4. id_pred_taken → id_pred_target
  5. id_pc+4, with wrap modulo 2^XLEN
- PC write enable = ex_br_mispred | ~id_stall. A mispredict overrides a stall. PC loads if_addr on the clock edge.
- Update (on clk edge when ex_update_valid):
  - Hit, taken: ctr saturating +1 (stays at 2^CTR_BITS-1); target ← ex_update_target.
  - Hit, not taken: ctr saturating −1 (stays at 0); target unchanged.
  - Miss (or tag mismatch), taken: allocate/overwrite; valid=1, tag, target, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
  - Updates are independent of id_stall and ex_br_mispred.
- Read/write collision: a lookup of the index being written this cycle returns the old contents. The new value is visible the next cycle.
- Latency: one cycle from update to prediction. if_addr reacts combinationally to all redirect inputs.

Test Plan:
- Reset then free-run, no events → if_addr=0x4000_0000, then 0x4000_0004 and 0x4000_0008 in successive cycles; id_pred_taken=0 throughout.
- Update pc=0x4000_0010 taken→0x4000_0100 (allocate); later id_pc=0x4000_0010 → id_pred_taken=1, if_addr=0x4000_0100.
- Same entry: 2 not-taken updates, CTR_BITS=2 → ctr 2→1→0; prediction falls to 0 after the first, if_addr=0x4000_0014. A third not-taken update keeps ctr=0.
- ex_br_mispred=1 with ex_redirect_pc=0x4000_0200 while id_stall=1 and id_pred_taken=1 → if_addr=0x4000_0200; id_pc=0x4000_0200 next cycle.
- id_stall=1 alone → id_pc held and if_addr=id_pc for 3 cycles. id_target_taken=1 while stalled → still held.
- Alias: entry for 0x4000_0010 valid; id_pc = 0x4000_0010 + 4*BTB_ENTRIES → tag mismatch, id_pred_taken=0. A not-taken update at the alias leaves the original entry intact.
